// File: rtl/axi_lite_req_arbiter.sv
// Round-robin arbiter sharing one single-beat AXI4 master port between NUM_REQ register requesters.
// Optional B/R wait timeout with late-beat drain is enabled by defining AXI_TIMEOUT_EN.
module axi_lite_req_arbiter #(
   parameter int unsigned NUM_REQ        = 4,
   parameter int unsigned AXI_ADDR_WIDTH = 32,
   parameter int unsigned AXI_DATA_WIDTH = 128,
   parameter int unsigned TIMEOUT_CYC    = 1024
) (
   input  logic                                s_axi_aclk,
   input  logic                                s_axi_areset,
   input  logic [NUM_REQ-1:0]                  req_valid,
   output logic [NUM_REQ-1:0]                  req_ready,
   input  logic [NUM_REQ-1:0]                  req_write,
   input  logic [NUM_REQ*AXI_ADDR_WIDTH-1:0]   req_addr,
   input  logic [NUM_REQ*AXI_DATA_WIDTH-1:0]   req_wdata,
   output logic [NUM_REQ-1:0]                  rsp_valid,
   output logic [AXI_DATA_WIDTH-1:0]           rsp_rdata,
   output logic [1:0]                          rsp_resp,
   output logic                                timeout_err,
   output logic [AXI_ADDR_WIDTH-1:0]           m_axi_awaddr,
   output logic [7:0]                          m_axi_awlen,
   output logic [2:0]                          m_axi_awsize,
   output logic [1:0]                          m_axi_awburst,
   output logic                                m_axi_awid,
   output logic                                m_axi_awvalid,
   input  logic                                m_axi_awready,
   output logic [AXI_DATA_WIDTH-1:0]           m_axi_wdata,
   output logic [AXI_DATA_WIDTH/8-1:0]         m_axi_wstrb,
   output logic                                m_axi_wlast,
   output logic                                m_axi_wvalid,
   input  logic                                m_axi_wready,
   input  logic [1:0]                          m_axi_bresp,
   input  logic                                m_axi_bvalid,
   output logic                                m_axi_bready,
   output logic [AXI_ADDR_WIDTH-1:0]           m_axi_araddr,
   output logic [7:0]                          m_axi_arlen,
   output logic [2:0]                          m_axi_arsize,
   output logic [1:0]                          m_axi_arburst,
   output logic                                m_axi_arid,
   output logic                                m_axi_arvalid,
   input  logic                                m_axi_arready,
   input  logic [AXI_DATA_WIDTH-1:0]           m_axi_rdata,
   input  logic [1:0]                          m_axi_rresp,
   input  logic                                m_axi_rlast,
   input  logic                                m_axi_rvalid,
   output logic                                m_axi_rready
);

   localparam int unsigned AW = AXI_ADDR_WIDTH;
   localparam int unsigned DW = AXI_DATA_WIDTH;
   localparam int unsigned SW = $clog2(NUM_REQ);
   localparam logic [SW-1:0] LAST_REQ = SW'(NUM_REQ - 1);
   localparam logic [31:0]   TO_BITS  = TIMEOUT_CYC;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_GRANT = 3'd1;
   localparam logic [2:0] S_AW_W  = 3'd2;
   localparam logic [2:0] S_B     = 3'd3;
   localparam logic [2:0] S_AR    = 3'd4;
   localparam logic [2:0] S_R     = 3'd5;
   localparam logic [2:0] S_RSP   = 3'd6;

   logic [2:0]    state;
   logic [SW-1:0] rr_ptr;
   logic [SW-1:0] sel_c;
   logic [SW-1:0] sel_q;
   logic [SW-1:0] idx;
   logic          any_req;
   logic          wr_q;
   logic [AW-1:0] addr_q;
   logic [DW-1:0] wdata_q;
   logic          drain;
   logic          unused_ok;

`ifdef AXI_TIMEOUT_EN
   localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);
   logic [CW-1:0] to_cnt;
   logic          drain_b;
   logic          drain_r;
   assign drain = drain_b | drain_r;
`else
   assign drain       = 1'b0;
   assign timeout_err = 1'b0;
`endif

   assign m_axi_awlen   = 8'h00;
   assign m_axi_arlen   = 8'h00;
   assign m_axi_awsize  = 3'($clog2(DW/8));
   assign m_axi_arsize  = 3'($clog2(DW/8));
   assign m_axi_awburst = 2'b01;
   assign m_axi_arburst = 2'b01;
   assign m_axi_awid    = 1'b0;
   assign m_axi_arid    = 1'b0;
   assign m_axi_wstrb   = {(DW/8){m_axi_wvalid}};
   assign m_axi_wlast   = m_axi_wvalid;
   assign unused_ok     = &{1'b0, m_axi_rlast, TO_BITS[0]};

   // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
   always_comb begin
      sel_c   = '0;
      any_req = 1'b0;
      idx     = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         idx = SW'((32'(rr_ptr) + k) % NUM_REQ);
         if (!any_req && req_valid[idx]) begin
            sel_c   = idx;
            any_req = 1'b1;
         end
      end
   end

   always_comb begin
      req_ready = '0;
      if (!s_axi_areset && state == S_IDLE && any_req && !drain)
         req_ready[sel_c] = 1'b1;
   end

   always_ff @(posedge s_axi_aclk) begin
      if (s_axi_areset) begin
         state         <= S_IDLE;
         rr_ptr        <= '0;
         sel_q         <= '0;
         wr_q          <= 1'b0;
         addr_q        <= '0;
         wdata_q       <= '0;
         rsp_valid     <= '0;
         rsp_rdata     <= '0;
         rsp_resp      <= '0;
         m_axi_awaddr  <= '0;
         m_axi_awvalid <= 1'b0;
         m_axi_wdata   <= '0;
         m_axi_wvalid  <= 1'b0;
         m_axi_bready  <= 1'b0;
         m_axi_araddr  <= '0;
         m_axi_arvalid <= 1'b0;
         m_axi_rready  <= 1'b0;
`ifdef AXI_TIMEOUT_EN
         to_cnt        <= '0;
         drain_b       <= 1'b0;
         drain_r       <= 1'b0;
         timeout_err   <= 1'b0;
`endif
      end else begin
         rsp_valid <= '0;
         case (state)
            S_IDLE: begin
               if (any_req && !drain) begin
                  sel_q   <= sel_c;
                  wr_q    <= req_write[sel_c];
                  addr_q  <= req_addr[sel_c*AW +: AW];
                  wdata_q <= req_wdata[sel_c*DW +: DW];
                  rr_ptr  <= (sel_c == LAST_REQ) ? '0 : sel_c + 1'b1;
                  state   <= S_GRANT;
               end
            end
            S_GRANT: begin
               if (wr_q) begin
                  m_axi_awaddr  <= addr_q;
                  m_axi_awvalid <= 1'b1;
                  m_axi_wdata   <= wdata_q;
                  m_axi_wvalid  <= 1'b1;
                  state         <= S_AW_W;
               end else begin
                  m_axi_araddr  <= addr_q;
                  m_axi_arvalid <= 1'b1;
                  state         <= S_AR;
               end
            end
            S_AW_W: begin
               if (m_axi_awvalid && m_axi_awready) m_axi_awvalid <= 1'b0;
               if (m_axi_wvalid && m_axi_wready)   m_axi_wvalid  <= 1'b0;
               // Each channel is done once its valid is low or handshaking this cycle.
               if ((!m_axi_awvalid || m_axi_awready) && (!m_axi_wvalid || m_axi_wready)) begin
                  m_axi_bready <= 1'b1;
                  state        <= S_B;
`ifdef AXI_TIMEOUT_EN
                  to_cnt       <= '0;
`endif
               end
            end
            S_B: begin
               if (m_axi_bvalid) begin
                  m_axi_bready     <= 1'b0;
                  rsp_resp         <= m_axi_bresp;
                  rsp_rdata        <= '0;
                  rsp_valid[sel_q] <= 1'b1;
                  state            <= S_RSP;
               end
`ifdef AXI_TIMEOUT_EN
               else if (to_cnt == CW'(TIMEOUT_CYC - 1)) begin
                  rsp_resp         <= 2'b10;
                  rsp_rdata        <= '0;
                  rsp_valid[sel_q] <= 1'b1;
                  timeout_err      <= 1'b1;
                  drain_b          <= 1'b1;
                  state            <= S_RSP;
               end else begin
                  to_cnt <= to_cnt + 1'b1;
               end
`endif
            end
            S_AR: begin
               if (m_axi_arready) begin
                  m_axi_arvalid <= 1'b0;
                  m_axi_rready  <= 1'b1;
                  state         <= S_R;
`ifdef AXI_TIMEOUT_EN
                  to_cnt        <= '0;
`endif
               end
            end
            S_R: begin
               if (m_axi_rvalid) begin
                  m_axi_rready     <= 1'b0;
                  rsp_resp         <= m_axi_rresp;
                  rsp_rdata        <= m_axi_rdata;
                  rsp_valid[sel_q] <= 1'b1;
                  state            <= S_RSP;
               end
`ifdef AXI_TIMEOUT_EN
               else if (to_cnt == CW'(TIMEOUT_CYC - 1)) begin
                  rsp_resp         <= 2'b10;
                  rsp_rdata        <= '0;
                  rsp_valid[sel_q] <= 1'b1;
                  timeout_err      <= 1'b1;
                  drain_r          <= 1'b1;
                  state            <= S_RSP;
               end else begin
                  to_cnt <= to_cnt + 1'b1;
               end
`endif
            end
            S_RSP:   state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
`ifdef AXI_TIMEOUT_EN
         // Ready stays high after a timeout so the late beat is swallowed before the next grant.
         if (state != S_B && state != S_R) begin
            if (drain_b && m_axi_bvalid) begin
               drain_b      <= 1'b0;
               m_axi_bready <= 1'b0;
            end
            if (drain_r && m_axi_rvalid) begin
               drain_r      <= 1'b0;
               m_axi_rready <= 1'b0;
            end
         end
`endif
      end
   end

endmodule

// File: tb/tb_axi_lite_req_arbiter.sv
// Directed bench for axi_lite_req_arbiter with a delay-configurable single-beat AXI slave model.
// The timeout scenario is built only when AXI_TIMEOUT_EN is defined.
module tb_axi_lite_req_arbiter;

   localparam int NR = 4;
   localparam int AW = 32;
   localparam int DW = 128;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [NR-1:0]     req_valid = '0;
   logic [NR-1:0]     req_ready;
   logic [NR-1:0]     req_write = '0;
   logic [NR*AW-1:0]  req_addr  = '0;
   logic [NR*DW-1:0]  req_wdata = '0;
   logic [NR-1:0]     rsp_valid;
   logic [DW-1:0]     rsp_rdata;
   logic [1:0]        rsp_resp;
   logic              timeout_err;
   logic [AW-1:0]     awaddr, araddr;
   logic [7:0]        awlen, arlen;
   logic [2:0]        awsize, arsize;
   logic [1:0]        awburst, arburst;
   logic              awid, arid;
   logic              awvalid, wvalid, arvalid, bready, rready, wlast;
   logic              awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0, rvalid = 1'b0;
   logic [DW-1:0]     wdata;
   logic [DW/8-1:0]   wstrb;
   logic [1:0]        bresp = '0, rresp = '0;
   logic [DW-1:0]     rdata = '0;
   logic              rlast = 1'b0;

   axi_lite_req_arbiter #(
      .NUM_REQ(NR), .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .TIMEOUT_CYC(16)
   ) dut (
      .s_axi_aclk(clk), .s_axi_areset(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .timeout_err(timeout_err),
      .m_axi_awaddr(awaddr), .m_axi_awlen(awlen), .m_axi_awsize(awsize), .m_axi_awburst(awburst),
      .m_axi_awid(awid), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
      .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wlast(wlast), .m_axi_wvalid(wvalid),
      .m_axi_wready(wready),
      .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
      .m_axi_araddr(araddr), .m_axi_arlen(arlen), .m_axi_arsize(arsize), .m_axi_arburst(arburst),
      .m_axi_arid(arid), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
      .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rlast(rlast), .m_axi_rvalid(rvalid),
      .m_axi_rready(rready)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   always @(posedge clk) cyc++;

   // Slave configuration (written by the test sequence) and observation state.
   int          aw_dly = 0, w_dly = 0;
   logic        b_hold = 1'b0, r_hold = 1'b0;
   logic [1:0]  bresp_cfg = '0, rresp_cfg = '0;
   logic [DW-1:0] rdata_cfg = '0;
   int          aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
   int          aw_wait = 0, w_wait = 0;
   logic        aw_done = 0, w_done = 0, ar_done = 0, b_rdy_prev = 0, r_rdy_prev = 0;
   logic [AW-1:0] cap_awaddr = '0, cap_araddr = '0;
   logic [7:0]  cap_awlen = '1, cap_arlen = '1;
   logic [2:0]  cap_awsize = '0, cap_arsize = '0;
   logic [1:0]  cap_awburst = '0;
   logic [DW-1:0] cap_wdata = '0;
   logic [DW/8-1:0] cap_wstrb = '0;
   logic        cap_wlast = 1'b0;

   always @(negedge clk) begin
      if (rst) begin
         awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0; rlast = 0;
         aw_wait = 0; w_wait = 0; aw_done = 0; w_done = 0; ar_done = 0;
         b_rdy_prev = 0; r_rdy_prev = 0;
      end else begin
         if (awready) begin
            awready = 0; aw_cnt++; aw_done = 1; aw_wait = 0;
         end else if (awvalid) begin
            if (aw_wait >= aw_dly) begin
               awready = 1; cap_awaddr = awaddr; cap_awlen = awlen;
               cap_awsize = awsize; cap_awburst = awburst;
            end else aw_wait++;
         end
         if (wready) begin
            wready = 0; w_cnt++; w_done = 1; w_wait = 0;
         end else if (wvalid) begin
            if (w_wait >= w_dly) begin
               wready = 1; cap_wdata = wdata; cap_wstrb = wstrb; cap_wlast = wlast;
            end else w_wait++;
         end
         if (bvalid && b_rdy_prev) begin
            bvalid = 0; b_cnt++;
         end else if (!bvalid && aw_done && w_done && !b_hold) begin
            bvalid = 1; bresp = bresp_cfg; aw_done = 0; w_done = 0;
         end
         b_rdy_prev = bready;
         if (arready) begin
            arready = 0; ar_cnt++; ar_done = 1;
         end else if (arvalid) begin
            arready = 1; cap_araddr = araddr; cap_arlen = arlen; cap_arsize = arsize;
         end
         if (rvalid && r_rdy_prev) begin
            rvalid = 0; rlast = 0; r_cnt++;
         end else if (!rvalid && ar_done && !r_hold) begin
            rvalid = 1; rlast = 1; rdata = rdata_cfg; rresp = rresp_cfg; ar_done = 0;
         end
         r_rdy_prev = rready;
      end
   end

   // Response and grant monitors.
   int          rsp_cnt = 0, rsp_at = 0, gnt_at = 0;
   logic [NR-1:0] last_rv = '0;
   logic [DW-1:0] last_rd = '0;
   logic [1:0]  last_rr = '0;
   int          grant_q[$];

   always @(negedge clk) begin
      if (!rst && |rsp_valid) begin
         rsp_cnt++; last_rv = rsp_valid; last_rd = rsp_rdata; last_rr = rsp_resp; rsp_at = cyc;
      end
      if (|req_ready) begin
         for (int i = 0; i < NR; i++) if (req_ready[i]) grant_q.push_back(i);
         gnt_at = cyc;
      end
   end

   localparam logic [DW-1:0] D_WR = 128'h0123_4567_89AB_CDEF_0F1E_2D3C_4B5A_DEAD;
   localparam logic [DW-1:0] D_RD = 128'hFEDC_BA98_7654_3210_A5A5_5A5A_0000_BEEF;

   task automatic issue(input int idx, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
      int n = 0;
      @(posedge clk); #1;
      req_write[idx] = wr; req_addr[idx*AW +: AW] = a; req_wdata[idx*DW +: DW] = d;
      req_valid[idx] = 1'b1;
      do begin @(negedge clk); n++; end while (!req_ready[idx] && n < 100);
      vectors++;
      if (!req_ready[idx]) begin
         miscompares++; $display("FAIL grant_timeout req%0d: req_ready=%b required bit set", idx, req_ready);
      end
      @(posedge clk); #1;
      req_valid[idx] = 1'b0;
   endtask

   task automatic wait_rsp(input int base);
      int n = 0;
      while (rsp_cnt == base && n < 400) begin @(posedge clk); #1; n++; end
      vectors++;
      if (rsp_cnt == base) begin
         miscompares++; $display("FAIL rsp_timeout: got no rsp_valid, required one");
      end
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; req_valid = '1;
      repeat (3) @(posedge clk);
      #1;
      vectors += 8;
      if (req_ready !== 4'b0000) begin miscompares++; $display("FAIL rst_req_ready: got %b required 0000", req_ready); end
      if (rsp_valid !== 4'b0000) begin miscompares++; $display("FAIL rst_rsp_valid: got %b required 0000", rsp_valid); end
      if ({awvalid, wvalid, arvalid, bready, rready} !== 5'b0) begin
         miscompares++; $display("FAIL rst_axi_valids: got %b required 00000", {awvalid, wvalid, arvalid, bready, rready});
      end
      if (timeout_err !== 1'b0) begin miscompares++; $display("FAIL rst_timeout_err: got %b required 0", timeout_err); end
      if (awlen !== 8'h0 || arlen !== 8'h0) begin miscompares++; $display("FAIL rst_len: got %h/%h required 00/00", awlen, arlen); end
      if (awsize !== 3'd4 || arsize !== 3'd4) begin miscompares++; $display("FAIL rst_size: got %0d/%0d required 4/4", awsize, arsize); end
      if (awburst !== 2'b01 || arburst !== 2'b01) begin miscompares++; $display("FAIL rst_burst: got %b/%b required 01/01", awburst, arburst); end
      if (rsp_resp !== 2'b00 || rsp_rdata !== '0) begin miscompares++; $display("FAIL rst_rsp_data: got %b/%h required 0/0", rsp_resp, rsp_rdata); end
      req_valid = '0; rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_fairness();
      int g0 = grant_q.size();
      int r0 = rsp_cnt;
      int n = 0;
      req_write = '0;
      for (int i = 0; i < NR; i++) req_addr[i*AW +: AW] = 32'h3000 + 32'(i * 16);
      req_valid = '1;
      while (grant_q.size() < g0 + 8 && n < 400) begin @(posedge clk); #1; n++; end
      req_valid = '0;
      n = 0;
      while (rsp_cnt < r0 + 8 && n < 100) begin @(posedge clk); #1; n++; end
      vectors++;
      if (grant_q.size() < g0 + 8) begin
         miscompares++; $display("FAIL fair_count: got %0d grants required 8", grant_q.size() - g0);
      end else begin
         for (int i = 0; i < 8; i++) begin
            vectors++;
            if (grant_q[g0+i] !== i % 4) begin
               miscompares++; $display("FAIL fair_order[%0d]: got req%0d required req%0d", i, grant_q[g0+i], i % 4);
            end
         end
      end
      vectors++;
      if (rsp_cnt !== r0 + 8) begin miscompares++; $display("FAIL fair_rsp_count: got %0d required 8", rsp_cnt - r0); end
   endtask

   task automatic test_single_write();
      int r0 = rsp_cnt, a0 = aw_cnt, w0 = w_cnt;
      aw_dly = 0; w_dly = 0; bresp_cfg = 2'b00;
      issue(0, 1'b1, 32'h1000, D_WR);
      wait_rsp(r0);
      vectors += 9;
      if (rsp_cnt !== r0 + 1) begin miscompares++; $display("FAIL wr_rsp_count: got %0d required 1", rsp_cnt - r0); end
      if (last_rv !== 4'b0001) begin miscompares++; $display("FAIL wr_rsp_valid: got %b required 0001", last_rv); end
      if (last_rr !== 2'b00 || last_rd !== '0) begin miscompares++; $display("FAIL wr_resp: got %b/%h required 00/0", last_rr, last_rd); end
      if (aw_cnt !== a0 + 1 || w_cnt !== w0 + 1) begin
         miscompares++; $display("FAIL wr_beats: got aw=%0d w=%0d required 1/1", aw_cnt - a0, w_cnt - w0);
      end
      if (cap_awaddr !== 32'h1000) begin miscompares++; $display("FAIL wr_awaddr: got %h required 00001000", cap_awaddr); end
      if (cap_awlen !== 8'h0 || cap_awsize !== 3'd4 || cap_awburst !== 2'b01) begin
         miscompares++; $display("FAIL wr_awattr: got len=%h size=%0d burst=%b required 00/4/01", cap_awlen, cap_awsize, cap_awburst);
      end
      if (cap_wdata !== D_WR) begin miscompares++; $display("FAIL wr_wdata: got %h required %h", cap_wdata, D_WR); end
      if (cap_wstrb !== 16'hFFFF || cap_wlast !== 1'b1) begin
         miscompares++; $display("FAIL wr_wstrb_wlast: got %h/%b required FFFF/1", cap_wstrb, cap_wlast);
      end
      if (rsp_at - gnt_at < 4) begin miscompares++; $display("FAIL wr_latency: got %0d cycles required >=4", rsp_at - gnt_at); end
   endtask

   task automatic test_read();
      int r0 = rsp_cnt, ar0 = ar_cnt, a0 = aw_cnt;
      rdata_cfg = D_RD; rresp_cfg = 2'b00;
      issue(2, 1'b0, 32'h2000, '0);
      wait_rsp(r0);
      vectors += 5;
      if (last_rv !== 4'b0100) begin miscompares++; $display("FAIL rd_rsp_valid: got %b required 0100", last_rv); end
      if (last_rd !== D_RD) begin miscompares++; $display("FAIL rd_rdata: got %h required %h", last_rd, D_RD); end
      if (last_rr !== 2'b00) begin miscompares++; $display("FAIL rd_resp: got %b required 00", last_rr); end
      if (cap_araddr !== 32'h2000 || cap_arlen !== 8'h0 || cap_arsize !== 3'd4) begin
         miscompares++; $display("FAIL rd_arattr: got %h/%h/%0d required 00002000/00/4", cap_araddr, cap_arlen, cap_arsize);
      end
      if (ar_cnt !== ar0 + 1 || aw_cnt !== a0 || rsp_cnt !== r0 + 1) begin
         miscompares++; $display("FAIL rd_beats: got ar=%0d aw=%0d rsp=%0d required 1/0/1", ar_cnt - ar0, aw_cnt - a0, rsp_cnt - r0);
      end
   endtask

   task automatic test_handshake_order();
      int aw_d[3] = '{3, 0, 0};
      int w_d[3]  = '{0, 3, 0};
      int who[3]  = '{1, 3, 0};
      for (int c = 0; c < 3; c++) begin
         int r0 = rsp_cnt, a0 = aw_cnt, w0 = w_cnt;
         logic [NR-1:0] exp_rv = '0;
         logic [DW-1:0] d = D_WR ^ DW'(c + 1);
         exp_rv[who[c]] = 1'b1;
         aw_dly = aw_d[c]; w_dly = w_d[c];
         issue(who[c], 1'b1, 32'h4000 + 32'(c), d);
         wait_rsp(r0);
         vectors += 4;
         if (aw_cnt !== a0 + 1 || w_cnt !== w0 + 1) begin
            miscompares++; $display("FAIL hs%0d_beats: got aw=%0d w=%0d required 1/1", c, aw_cnt - a0, w_cnt - w0);
         end
         if (rsp_cnt !== r0 + 1) begin miscompares++; $display("FAIL hs%0d_rsp_count: got %0d required 1", c, rsp_cnt - r0); end
         if (last_rv !== exp_rv) begin miscompares++; $display("FAIL hs%0d_rsp_valid: got %b required %b", c, last_rv, exp_rv); end
         if (cap_wdata !== d || cap_awaddr !== 32'h4000 + 32'(c)) begin
            miscompares++; $display("FAIL hs%0d_payload: got %h@%h required %h@%h", c, cap_wdata, cap_awaddr, d, 32'h4000 + 32'(c));
         end
      end
      aw_dly = 0; w_dly = 0;
   endtask

   task automatic test_error_resp();
      int r0 = rsp_cnt;
      bresp_cfg = 2'b10;
      issue(1, 1'b1, 32'h5000, D_WR);
      wait_rsp(r0);
      vectors += 2;
      if (last_rr !== 2'b10 || last_rd !== '0) begin miscompares++; $display("FAIL err_bresp: got %b/%h required 10/0", last_rr, last_rd); end
      if (last_rv !== 4'b0010) begin miscompares++; $display("FAIL err_b_rsp_valid: got %b required 0010", last_rv); end
      bresp_cfg = 2'b00;
      r0 = rsp_cnt; rresp_cfg = 2'b11; rdata_cfg = D_RD;
      issue(3, 1'b0, 32'h5004, '0);
      wait_rsp(r0);
      vectors += 2;
      if (last_rr !== 2'b11 || last_rd !== D_RD) begin miscompares++; $display("FAIL err_rresp: got %b/%h required 11/%h", last_rr, last_rd, D_RD); end
      if (last_rv !== 4'b1000) begin miscompares++; $display("FAIL err_r_rsp_valid: got %b required 1000", last_rv); end
      rresp_cfg = 2'b00;
   endtask

   task automatic test_reset_in_r();
      int r0 = rsp_cnt;
      int n = 0;
      r_hold = 1'b1;
      issue(1, 1'b0, 32'h6000, '0);
      while (!rready && n < 50) begin @(posedge clk); #1; n++; end
      vectors++;
      if (rready !== 1'b1) begin miscompares++; $display("FAIL rstR_reach_r: got rready=%b required 1", rready); end
      rst = 1'b1;
      @(posedge clk); #1;
      vectors += 2;
      if ({awvalid, wvalid, arvalid, bready, rready} !== 5'b0) begin
         miscompares++; $display("FAIL rstR_valids: got %b required 00000", {awvalid, wvalid, arvalid, bready, rready});
      end
      if (rsp_valid !== 4'b0000) begin miscompares++; $display("FAIL rstR_rsp_valid: got %b required 0000", rsp_valid); end
      rst = 1'b0; r_hold = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      vectors++;
      if (rsp_cnt !== r0) begin miscompares++; $display("FAIL rstR_no_rsp: got %0d responses required 0", rsp_cnt - r0); end
      // Pointer was 2 before reset; a full request set must now grant requester 0.
      req_write = '0; req_valid = '1;
      @(negedge clk);
      vectors++;
      if (req_ready !== 4'b0001) begin miscompares++; $display("FAIL rstR_ptr: got req_ready=%b required 0001", req_ready); end
      @(posedge clk); #1;
      req_valid = '0;
      wait_rsp(r0);
      vectors++;
      if (last_rv !== 4'b0001) begin miscompares++; $display("FAIL rstR_after_rsp: got %b required 0001", last_rv); end
   endtask

`ifdef AXI_TIMEOUT_EN
   task automatic test_timeout();
      int r0 = rsp_cnt, b0 = b_cnt;
      int n = 0, b_at;
      b_hold = 1'b1;
      issue(0, 1'b1, 32'h7000, D_WR);
      while (!bready && n < 50) begin @(posedge clk); #1; n++; end
      b_at = cyc;
      wait_rsp(r0);
      vectors += 4;
      if (last_rr !== 2'b10 || last_rd !== '0) begin miscompares++; $display("FAIL to_resp: got %b/%h required 10/0", last_rr, last_rd); end
      if (rsp_at - b_at !== 16) begin miscompares++; $display("FAIL to_cycles: got %0d required 16", rsp_at - b_at); end
      if (timeout_err !== 1'b1) begin miscompares++; $display("FAIL to_err: got %b required 1", timeout_err); end
      if (bready !== 1'b1) begin miscompares++; $display("FAIL to_drain_ready: got %b required 1", bready); end
      r0 = rsp_cnt;
      b_hold = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      vectors += 2;
      if (b_cnt !== b0 + 1 || bready !== 1'b0) begin
         miscompares++; $display("FAIL to_drain: got b=%0d bready=%b required 1/0", b_cnt - b0, bready);
      end
      if (rsp_cnt !== r0) begin miscompares++; $display("FAIL to_drain_silent: got %0d responses required 0", rsp_cnt - r0); end
      issue(2, 1'b1, 32'h7010, D_WR);
      wait_rsp(r0);
      vectors += 2;
      if (last_rr !== 2'b00 || last_rv !== 4'b0100) begin
         miscompares++; $display("FAIL to_next: got %b/%b required 00/0100", last_rr, last_rv);
      end
      if (timeout_err !== 1'b1) begin miscompares++; $display("FAIL to_sticky: got %b required 1", timeout_err); end
   endtask
`endif

   initial begin
      test_reset();
      test_fairness();
      test_single_write();
      test_read();
      test_handshake_order();
      test_error_resp();
      test_reset_in_r();
`ifdef AXI_TIMEOUT_EN
      test_timeout();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish, required completion");
      $fatal(1);
   end

endmodule
